dbg_run_ctrl: RTL and testbench

//  Parametrised run-control and debug-readback unit placed between board I/O and the CPU core.

---
 rtl/dbg_run_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dbg_run_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_run_ctrl.sv
// Run control (start edge -> launch pulse, run/halt tracking, run cycle count) and debug RF/DM readback.
// Defining DBG_SCAN_EN adds a streamed dump of the whole RF then DM on the scan_* ports.
module dbg_run_ctrl #(
   parameter int DATA_W    = 8,
   parameter int RF_ADDR_W = 2,
   parameter int DM_ADDR_W = 4,
   parameter int RD_LAT    = 1,
   parameter int CYC_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 cpu_stopped,
   output logic                 cpu_start,
   output logic                 running,
   output logic                 stopped,
   output logic [CYC_W-1:0]     run_cycles,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_sel,
   input  logic [DM_ADDR_W-1:0] req_addr,
   output logic                 rsp_valid,
   output logic [DATA_W-1:0]    rsp_data,
   output logic [RF_ADDR_W-1:0] dbg_rf_addr,
   output logic [DM_ADDR_W-1:0] dbg_dm_addr,
   input  logic [DATA_W-1:0]    dbg_rf_data,
   input  logic [DATA_W-1:0]    dbg_dm_data,
`ifdef DBG_SCAN_EN
   input  logic                 scan_go,
   output logic                 scan_valid,
   input  logic                 scan_ready,
   output logic [DATA_W-1:0]    scan_data,
   output logic                 scan_last,
`endif
   output logic [1:0]           fsm_state
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // an offered word keeps valid high and its data stable until that edge.

   typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2, HALT = 2'd3} state_e;
   localparam int LAT_W = $clog2(RD_LAT + 1);

   state_e              state, state_nx;
   logic                start_q, start_edge, alive, pend, idle_halt;
   logic                fetch_busy, rd_sel, scan_busy, accept, scan_accept, launch_go;
   logic [LAT_W-1:0]    lat_cnt;
   logic [DATA_W-1:0]   rd_data;

   assign start_edge = start & ~start_q;
   assign idle_halt  = (state == IDLE) || (state == HALT);
   assign req_ready  = alive && idle_halt && !fetch_busy && !pend && !scan_busy;
   assign accept     = req_valid && req_ready;
   // A start edge that collides with any debug traffic waits in pend until the traffic drains.
   assign launch_go  = idle_halt && (start_edge || pend) && !fetch_busy && !scan_busy
                       && !accept && !scan_accept;
   assign rd_data    = rd_sel ? dbg_dm_data : dbg_rf_data;

   assign cpu_start  = (state == LAUNCH);
   assign running    = (state == LAUNCH) || (state == RUN);
   assign stopped    = (state == HALT);
   assign fsm_state  = state;

`ifdef DBG_SCAN_EN
   localparam int RF_N   = 1 << RF_ADDR_W;
   localparam int SCAN_N = RF_N + (1 << DM_ADDR_W);
   localparam int IDX_W  = $clog2(SCAN_N);

   logic                 scan_act, scan_hs;
   logic [IDX_W-1:0]     scan_idx, scan_nxt;
   logic [DM_ADDR_W-1:0] dm_off;

   assign scan_busy   = scan_act;
   assign scan_accept = scan_go && req_ready;
   assign scan_hs     = scan_valid && scan_ready;
   assign scan_last   = scan_valid && (scan_idx == IDX_W'(SCAN_N - 1));
   assign scan_nxt    = scan_idx + IDX_W'(1);
   assign dm_off      = DM_ADDR_W'(scan_nxt - IDX_W'(RF_N));
`else
   assign scan_busy   = 1'b0;
   assign scan_accept = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, HALT: if (launch_go) state_nx = LAUNCH;
         LAUNCH:     state_nx = RUN;
         RUN:        if (cpu_stopped) state_nx = HALT;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         alive      <= 1'b0;
         pend       <= 1'b0;
         run_cycles <= '0;
      end else begin
         state   <= state_nx;
         start_q <= start;
         alive   <= 1'b1;
         if (launch_go)
            pend <= 1'b0;
         else if (start_edge && idle_halt)
            pend <= 1'b1;
         if (state == LAUNCH)
            run_cycles <= '0;
         else if (state == RUN && run_cycles != '1)
            run_cycles <= run_cycles + CYC_W'(1);
      end
   end

   // One shared fetch engine: drive address, wait RD_LAT cycles, capture on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_busy  <= 1'b0;
         lat_cnt     <= '0;
         rd_sel      <= 1'b0;
         dbg_rf_addr <= '0;
         dbg_dm_addr <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
`ifdef DBG_SCAN_EN
         scan_act    <= 1'b0;
         scan_idx    <= '0;
         scan_valid  <= 1'b0;
         scan_data   <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         if (accept) begin
            fetch_busy  <= 1'b1;
            lat_cnt     <= LAT_W'(RD_LAT);
            rd_sel      <= req_sel;
            dbg_rf_addr <= req_addr[RF_ADDR_W-1:0];
            dbg_dm_addr <= req_addr;
         end
`ifdef DBG_SCAN_EN
         else if (scan_accept) begin
            scan_act    <= 1'b1;
            scan_idx    <= '0;
            fetch_busy  <= 1'b1;
            lat_cnt     <= LAT_W'(RD_LAT);
            rd_sel      <= 1'b0;
            dbg_rf_addr <= '0;
         end else if (scan_hs) begin
            scan_valid <= 1'b0;
            if (scan_last) begin
               scan_act <= 1'b0;
            end else begin
               scan_idx   <= scan_nxt;
               fetch_busy <= 1'b1;
               lat_cnt    <= LAT_W'(RD_LAT);
               if (scan_nxt < IDX_W'(RF_N)) begin
                  rd_sel      <= 1'b0;
                  dbg_rf_addr <= scan_nxt[RF_ADDR_W-1:0];
               end else begin
                  rd_sel      <= 1'b1;
                  dbg_dm_addr <= dm_off;
               end
            end
         end
`endif
         else if (fetch_busy) begin
            if (lat_cnt != '0) begin
               lat_cnt <= lat_cnt - LAT_W'(1);
            end else begin
               fetch_busy <= 1'b0;
`ifdef DBG_SCAN_EN
               if (scan_act) begin
                  scan_valid <= 1'b1;
                  scan_data  <= rd_data;
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= rd_data;
               end
`else
               rsp_valid <= 1'b1;
               rsp_data  <= rd_data;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed bench for dbg_run_ctrl (RD_LAT=2, CYC_W=4); the scan dump is exercised when DBG_SCAN_EN is defined.
module tb_dbg_run_ctrl;
   localparam int DATA_W = 8;
   localparam int RF_W   = 2;
   localparam int DM_W   = 4;
   localparam int RD_LAT = 2;
   localparam int CYC_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n, start, cpu_stopped, req_valid, req_sel;
   logic [DM_W-1:0]   req_addr;
   logic              cpu_start, running, stopped, req_ready, rsp_valid;
   logic [CYC_W-1:0]  run_cycles;
   logic [DATA_W-1:0] rsp_data, dbg_rf_data, dbg_dm_data;
   logic [RF_W-1:0]   dbg_rf_addr;
   logic [DM_W-1:0]   dbg_dm_addr;
   logic [1:0]        fsm_state;
`ifdef DBG_SCAN_EN
   logic              scan_go, scan_valid, scan_ready, scan_last;
   logic [DATA_W-1:0] scan_data;
   logic [DATA_W-1:0] exp_q[$];
`endif

   logic [DATA_W-1:0] rf_mem [4];
   logic [DATA_W-1:0] dm_mem [16];
   logic [RF_W-1:0]   rf_pipe [RD_LAT];
   logic [DM_W-1:0]   dm_pipe [RD_LAT];
   int n_tests = 0;
   int n_fail  = 0;

   // clock / reset
   always #5 clk = ~clk;

   // CPU debug ports: data appears RD_LAT cycles after the address is driven
   always @(posedge clk) begin
      rf_pipe[0] <= dbg_rf_addr;
      dm_pipe[0] <= dbg_dm_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         rf_pipe[i] <= rf_pipe[i-1];
         dm_pipe[i] <= dm_pipe[i-1];
      end
   end
   assign dbg_rf_data = rf_mem[rf_pipe[RD_LAT-1]];
   assign dbg_dm_data = dm_mem[dm_pipe[RD_LAT-1]];

   dbg_run_ctrl #(
      .DATA_W(DATA_W), .RF_ADDR_W(RF_W), .DM_ADDR_W(DM_W), .RD_LAT(RD_LAT), .CYC_W(CYC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cpu_stopped(cpu_stopped),
      .cpu_start(cpu_start), .running(running), .stopped(stopped), .run_cycles(run_cycles),
      .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .dbg_rf_addr(dbg_rf_addr), .dbg_dm_addr(dbg_dm_addr),
      .dbg_rf_data(dbg_rf_data), .dbg_dm_data(dbg_dm_data),
`ifdef DBG_SCAN_EN
      .scan_go(scan_go), .scan_valid(scan_valid), .scan_ready(scan_ready),
      .scan_data(scan_data), .scan_last(scan_last),
`endif
      .fsm_state(fsm_state)
   );

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cpu_start"}, 32'(cpu_start), 0);
      check({tag, "_running"},   32'(running), 0);
      check({tag, "_stopped"},   32'(stopped), 0);
      check({tag, "_cycles"},    32'(run_cycles), 0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      check({tag, "_rsp_data"},  32'(rsp_data), 0);
      check({tag, "_rf_addr"},   32'(dbg_rf_addr), 0);
      check({tag, "_dm_addr"},   32'(dbg_dm_addr), 0);
      check({tag, "_state"},     32'(fsm_state), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rf_mem[0] = 8'hA1; rf_mem[1] = 8'hB2; rf_mem[2] = 8'h5A; rf_mem[3] = 8'hC4;
      for (int i = 0; i < 16; i++) dm_mem[i] = 8'(8'h30 + i * 5);
      dm_mem[9] = 8'hC3;
      rst_n = 1'b0; start = 1'b0; cpu_stopped = 1'b0;
      req_valid = 1'b0; req_sel = 1'b0; req_addr = '0;
`ifdef DBG_SCAN_EN
      scan_go = 1'b0; scan_ready = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("in_reset");
      check("in_reset_req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      tick();

      // reset state
      check_all_zero("post_reset");
      check("post_reset_req_ready", 32'(req_ready), 1);

      // start edge, CPU halts 10 cycles after the launch pulse
      start = 1'b1;
      tick();
      check("launch_cpu_start", 32'(cpu_start), 1);
      check("launch_state", 32'(fsm_state), 1);
      check("launch_req_ready", 32'(req_ready), 0);
      tick();
      check("run1_cpu_start", 32'(cpu_start), 0);
      check("run1_running", 32'(running), 1);
      check("run1_cycles", 32'(run_cycles), 0);
      repeat (9) tick();
      cpu_stopped = 1'b1;
      tick();
      check("halt_stopped", 32'(stopped), 1);
      check("halt_running", 32'(running), 0);
      check("halt_cycles", 32'(run_cycles), 10);
      repeat (2) tick();
      check("halt_cycles_frozen", 32'(run_cycles), 10);

      // RF read in HALT: addr 4'hE maps to RF[2]
      req_valid = 1'b1; req_sel = 1'b0; req_addr = 4'hE;
      check("rf_req_ready", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      check("rf_busy_ready", 32'(req_ready), 0);
      check("rf_addr", 32'(dbg_rf_addr), 2);
      check("rf_lat1_valid", 32'(rsp_valid), 0);
      tick();
      check("rf_lat2_valid", 32'(rsp_valid), 0);
      tick();
      check("rf_lat3_valid", 32'(rsp_valid), 0);
      tick();
      check("rf_rsp_valid", 32'(rsp_valid), 1);
      check("rf_rsp_data", 32'(rsp_data), 32'h5A);
      tick();
      check("rf_rsp_pulse", 32'(rsp_valid), 0);
      check("rf_rsp_held", 32'(rsp_data), 32'h5A);
      check("rf_ready_again", 32'(req_ready), 1);

      // 20-cycle run saturates a 4-bit counter; a start edge during RUN is ignored
      start = 1'b0;
      tick();
      start = 1'b1; cpu_stopped = 1'b0;
      tick();
      check("sat_launch", 32'(cpu_start), 1);
      tick();
      check("sat_cycles_cleared", 32'(run_cycles), 0);
      start = 1'b0;
      tick();
      start = 1'b1;
      repeat (14) tick();
      check("sat_cycles_15", 32'(run_cycles), 15);
      tick();
      check("sat_cycles_hold", 32'(run_cycles), 15);
      repeat (3) tick();
      cpu_stopped = 1'b1;
      tick();
      check("sat_halt_cycles", 32'(run_cycles), 15);
      check("sat_halt_stopped", 32'(stopped), 1);
      tick();
      check("run_edge_ignored_state", 32'(fsm_state), 3);
      check("run_edge_ignored_start", 32'(cpu_start), 0);

      // start edge in the same cycle as a DM read accept
      start = 1'b0;
      tick();
      start = 1'b1; cpu_stopped = 1'b0;
      req_valid = 1'b1; req_sel = 1'b1; req_addr = 4'd9;
      check("coll_req_ready", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      check("coll_ready_low", 32'(req_ready), 0);
      check("coll_dm_addr", 32'(dbg_dm_addr), 9);
      check("coll_no_launch1", 32'(cpu_start), 0);
      tick();
      tick();
      check("coll_no_launch3", 32'(cpu_start), 0);
      check("coll_ready_low3", 32'(req_ready), 0);
      tick();
      check("coll_rsp_valid", 32'(rsp_valid), 1);
      check("coll_rsp_data", 32'(rsp_data), 32'hC3);
      check("coll_no_launch4", 32'(cpu_start), 0);
      check("coll_pend_ready", 32'(req_ready), 0);
      tick();
      check("coll_launch", 32'(cpu_start), 1);
      check("coll_launch_ready", 32'(req_ready), 0);
      tick();
      check("coll_run_cycles", 32'(run_cycles), 0);
      cpu_stopped = 1'b1;
      tick();
      check("coll_halt", 32'(fsm_state), 3);
      check("coll_halt_cycles", 32'(run_cycles), 1);

      // back-to-back reads, then a reset while the second is in flight
      req_valid = 1'b1; req_sel = 1'b0; req_addr = 4'd1;
      check("b2b_ready0", 32'(req_ready), 1);
      tick();
      tick();
      tick();
      check("b2b_ready3", 32'(req_ready), 0);
      tick();
      check("b2b_rsp_valid", 32'(rsp_valid), 1);
      check("b2b_rsp_data", 32'(rsp_data), 32'hB2);
      check("b2b_ready4", 32'(req_ready), 1);
      req_addr = 4'd3;
      tick();
      req_valid = 1'b0;
      check("b2b_second_addr", 32'(dbg_rf_addr), 3);
      tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_read_reset");
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("dropped_rsp", 32'(rsp_valid), 0);
      end
      check("dropped_ready", 32'(req_ready), 1);

`ifdef DBG_SCAN_EN
      // scan dump with scan_ready toggling every other cycle
      begin
         int got = 0;
         int cyc = 0;
         logic stall_hold = 1'b0;
         logic [DATA_W-1:0] held = '0;
         logic [DATA_W-1:0] exp;
         for (int i = 0; i < 4; i++) exp_q.push_back(rf_mem[i]);
         for (int i = 0; i < 16; i++) exp_q.push_back(dm_mem[i]);
         scan_go = 1'b1;
         tick();
         scan_go = 1'b0;
         check("scan_req_ready", 32'(req_ready), 0);
         while (got < 20 && cyc < 1000) begin
            scan_ready = cyc[0];
            if (stall_hold) begin
               check("scan_stall_valid", 32'(scan_valid), 1);
               check("scan_stall_data", 32'(scan_data), 32'(held));
            end
            stall_hold = 1'b0;
            if (scan_valid) begin
               if (scan_ready) begin
                  exp = exp_q.pop_front();
                  check("scan_data", 32'(scan_data), 32'(exp));
                  check("scan_last", 32'(scan_last), 32'(got == 19));
                  got++;
               end else begin
                  stall_hold = 1'b1;
                  held = scan_data;
               end
            end
            tick();
            cyc++;
         end
         scan_ready = 1'b0;
         check("scan_word_count", 32'(got), 20);
         tick();
         check("scan_done_valid", 32'(scan_valid), 0);
         check("scan_done_ready", 32'(req_ready), 1);
      end
`endif

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
